// File: rtl/tiny32_mem_arbiter.sv
// tiny32_mem_arbiter
//   Shares one 64-bit memory bus between the instruction-fetch port (128-bit
//   line, issued as two 64-bit beats) and the data load/store port.
//   Round-robin grant on simultaneous requests, optional per-beat timeout.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | bus idle, arbitrate between i_req and d_req
//   IF0   | fetch beat 0 on the bus (line address + 0)
//   IF1   | fetch beat 1 on the bus (line address + 8)
//   DACC  | single data beat on the bus (load or store)
//   ACK   | one-cycle completion pulse to the granted port
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_adr              fetch request, 16-byte aligned line address
//   i_ack/i_err/i_dat        fetch completion pulse, timeout flag, line data
//   d_req/d_wr/d_sel/d_adr/d_dato   data request, 8-byte aligned
//   d_ack/d_err/d_dati       data completion pulse, timeout flag, load data
//   m_cyc/m_we/m_sel/m_adr/m_dato   memory bus master outputs
//   m_ack/m_dati             memory bus beat acknowledge and read data
module tiny32_mem_arbiter #(
  parameter int AW      = 24,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_adr,
  output logic          i_ack,
  output logic          i_err,
  output logic [127:0]  i_dat,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [7:0]    d_sel,
  input  logic [AW-1:0] d_adr,
  input  logic [63:0]   d_dato,
  output logic          d_ack,
  output logic          d_err,
  output logic [63:0]   d_dati,
  output logic          m_cyc,
  output logic          m_we,
  output logic [7:0]    m_sel,
  output logic [AW-1:0] m_adr,
  output logic [63:0]   m_dato,
  input  logic          m_ack,
  input  logic [63:0]   m_dati
);

  typedef enum logic [2:0] {IDLE, IF0, IF1, DACC, ACK} state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Beat timer counts down from TIMEOUT-1; reaching zero without m_ack aborts.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state, state_nxt;
  logic            last_gnt, last_gnt_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [63:0]     beat0, beat0_nxt;
  logic            timed_out;

  logic            i_ack_nxt, i_err_nxt, d_ack_nxt, d_err_nxt;
  logic [127:0]    i_dat_nxt;
  logic [63:0]     d_dati_nxt, m_dato_nxt;
  logic            m_cyc_nxt, m_we_nxt;
  logic [7:0]      m_sel_nxt;
  logic [AW-1:0]   m_adr_nxt;

  // Low address bits are alignment-only and intentionally ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_adr[3:0], d_adr[2:0]};

  assign timed_out = (TIMEOUT != 0) && (tmr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= GNT_D;
      tmr      <= '0;
      beat0    <= '0;
      i_ack    <= 1'b0;
      i_err    <= 1'b0;
      i_dat    <= '0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      d_dati   <= '0;
      m_cyc    <= 1'b0;
      m_we     <= 1'b0;
      m_sel    <= '0;
      m_adr    <= '0;
      m_dato   <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      tmr      <= tmr_nxt;
      beat0    <= beat0_nxt;
      i_ack    <= i_ack_nxt;
      i_err    <= i_err_nxt;
      i_dat    <= i_dat_nxt;
      d_ack    <= d_ack_nxt;
      d_err    <= d_err_nxt;
      d_dati   <= d_dati_nxt;
      m_cyc    <= m_cyc_nxt;
      m_we     <= m_we_nxt;
      m_sel    <= m_sel_nxt;
      m_adr    <= m_adr_nxt;
      m_dato   <= m_dato_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    tmr_nxt      = tmr;
    beat0_nxt    = beat0;
    i_ack_nxt    = 1'b0;
    i_err_nxt    = i_err;
    i_dat_nxt    = i_dat;
    d_ack_nxt    = 1'b0;
    d_err_nxt    = d_err;
    d_dati_nxt   = d_dati;
    m_cyc_nxt    = m_cyc;
    m_we_nxt     = m_we;
    m_sel_nxt    = m_sel;
    m_adr_nxt    = m_adr;
    m_dato_nxt   = m_dato;

    case (state)
      IDLE: begin
        // Tie goes to whichever port was not served last.
        if (i_req && (!d_req || last_gnt == GNT_D)) begin
          state_nxt    = IF0;
          last_gnt_nxt = GNT_I;
          tmr_nxt      = TMR_LOAD;
          m_cyc_nxt    = 1'b1;
          m_we_nxt     = 1'b0;
          m_sel_nxt    = 8'hFF;
          m_adr_nxt    = {i_adr[AW-1:4], 4'h0};
          m_dato_nxt   = '0;
        end else if (d_req) begin
          state_nxt    = DACC;
          last_gnt_nxt = GNT_D;
          tmr_nxt      = TMR_LOAD;
          m_cyc_nxt    = 1'b1;
          m_we_nxt     = d_wr;
          m_sel_nxt    = d_sel;
          m_adr_nxt    = {d_adr[AW-1:3], 3'b000};
          m_dato_nxt   = d_dato;
        end
      end

      IF0: begin
        if (m_ack) begin
          state_nxt = IF1;
          beat0_nxt = m_dati;
          tmr_nxt   = TMR_LOAD;
          m_adr_nxt = m_adr + AW'(8);
        end else if (timed_out) begin
          state_nxt = ACK;
          m_cyc_nxt = 1'b0;
          i_ack_nxt = 1'b1;
          i_err_nxt = 1'b1;
          i_dat_nxt = '0;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end

      IF1: begin
        if (m_ack) begin
          state_nxt = ACK;
          m_cyc_nxt = 1'b0;
          i_ack_nxt = 1'b1;
          i_err_nxt = 1'b0;
          i_dat_nxt = {m_dati, beat0};
        end else if (timed_out) begin
          state_nxt = ACK;
          m_cyc_nxt = 1'b0;
          i_ack_nxt = 1'b1;
          i_err_nxt = 1'b1;
          i_dat_nxt = '0;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end

      DACC: begin
        if (m_ack) begin
          state_nxt = ACK;
          m_cyc_nxt = 1'b0;
          d_ack_nxt = 1'b1;
          d_err_nxt = 1'b0;
          // Stores leave the previous load data in place.
          if (!m_we) d_dati_nxt = m_dati;
        end else if (timed_out) begin
          state_nxt  = ACK;
          m_cyc_nxt  = 1'b0;
          d_ack_nxt  = 1'b1;
          d_err_nxt  = 1'b1;
          d_dati_nxt = '0;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end

      ACK: begin
        state_nxt = IDLE;
        i_err_nxt = 1'b0;
        d_err_nxt = 1'b0;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tiny32_mem_arbiter.sv
// Testbench for tiny32_mem_arbiter: reset state, round-robin tie sequence,
// reset in the middle of a fetch, a table of single transactions (incl.
// wait states and timeouts) and a randomized two-requester run against a
// transaction-level reference model.
module tb_tiny32_mem_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [23:0]   i_adr = '0;
  logic          i_ack, i_err;
  logic [127:0]  i_dat;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [7:0]    d_sel = '0;
  logic [23:0]   d_adr = '0;
  logic [63:0]   d_dato = '0;
  logic          d_ack, d_err;
  logic [63:0]   d_dati;
  logic          m_cyc, m_we;
  logic [7:0]    m_sel;
  logic [23:0]   m_adr;
  logic [63:0]   m_dato;
  logic          m_ack = 1'b0;
  logic [63:0]   m_dati = '0;

  int checks = 0;
  int errors = 0;

  tiny32_mem_arbiter #(.AW(24), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_err(i_err), .i_dat(i_dat),
    .d_req(d_req), .d_wr(d_wr), .d_sel(d_sel), .d_adr(d_adr), .d_dato(d_dato),
    .d_ack(d_ack), .d_err(d_err), .d_dati(d_dati),
    .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dato(m_dato),
    .m_ack(m_ack), .m_dati(m_dati)
  );

  always #5 clk = ~clk;

  // Default memory contents as a function of the beat address.
  function automatic logic [63:0] pat(input logic [23:0] a);
    return {a, 8'h5A, ~a, 8'hC3};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- bus slave model ----------------
  logic [63:0] bus_rd_q[$];
  int          bus_ws = 0;
  bit          bus_mute = 1'b0;
  bit          ws_rand = 1'b0;
  int          age = 0;

  always begin
    @(posedge clk);
    #1;
    if (rst || !m_cyc || bus_mute) begin
      m_ack = 1'b0;
      age   = 0;
    end else begin
      if (m_ack) begin
        age = 0;
        if (ws_rand) bus_ws = $urandom_range(0, 3);
      end
      if (age >= bus_ws) begin
        m_ack = 1'b1;
        if (bus_rd_q.size() > 0) m_dati = bus_rd_q.pop_front();
        else m_dati = pat(m_adr);
      end else begin
        m_ack  = 1'b0;
        m_dati = {$urandom, $urandom};
        age++;
      end
    end
  end

  task automatic do_reset();
    i_req = 1'b0;
    d_req = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------- table of single transactions ----------------
  typedef struct {
    logic         fetch;
    logic         wr;
    logic [7:0]   sel;
    logic [23:0]  adr;
    logic [63:0]  dato;
    int           ws;        // wait states per beat, -1 = bus never acks
    logic [63:0]  rd0;
    logic [63:0]  rd1;
    logic [23:0]  exp_a0;
    logic [23:0]  exp_a1;
    int           exp_lat;   // cycles from request to ack
    logic         exp_err;
    logic [127:0] exp_dat;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int          n, ncyc, nbeat;
    bit          acked, first;
    logic [23:0] a_first, beat_a1;
    logic        f_we;
    logic [7:0]  f_sel;
    logic [63:0] f_dato;
    logic [127:0] got_dat;
    logic        got_err;
    string       p;
    p = $sformatf("vec%0d", idx);
    bus_mute = (v.ws < 0);
    bus_ws   = (v.ws < 0) ? 0 : v.ws;
    ws_rand  = 1'b0;
    bus_rd_q.delete();
    if (v.ws >= 0) begin
      bus_rd_q.push_back(v.rd0);
      if (v.fetch) bus_rd_q.push_back(v.rd1);
    end
    if (v.fetch) begin
      i_adr = v.adr;
      i_req = 1'b1;
    end else begin
      d_wr   = v.wr;
      d_sel  = v.sel;
      d_adr  = v.adr;
      d_dato = v.dato;
      d_req  = 1'b1;
    end
    n = 0; ncyc = 0; nbeat = 0; acked = 1'b0; first = 1'b1;
    a_first = '0; beat_a1 = '0; f_we = 1'b0; f_sel = '0; f_dato = '0;
    got_dat = '0; got_err = 1'b0;
    while (!acked && n < 200) begin
      @(posedge clk);
      #2;
      n++;
      if (m_cyc) begin
        ncyc++;
        if (first) begin
          a_first = m_adr; f_we = m_we; f_sel = m_sel; f_dato = m_dato;
          first = 1'b0;
        end
        if (m_ack) begin
          if (nbeat == 1) beat_a1 = m_adr;
          nbeat++;
        end
      end
      if (v.fetch ? i_ack : d_ack) begin
        acked   = 1'b1;
        got_err = v.fetch ? i_err : d_err;
        got_dat = v.fetch ? i_dat : {64'h0, d_dati};
        chk({p, "_other_ack"}, v.fetch ? d_ack : i_ack, 1'b0);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk({p, "_acked"}, acked, 1'b1);
    chk({p, "_latency"}, n, v.exp_lat);
    chk({p, "_mcyc_cycles"}, ncyc, v.exp_lat - 1);
    chk({p, "_adr0"}, a_first, v.exp_a0);
    if (v.fetch && !v.exp_err) chk({p, "_adr1"}, beat_a1, v.exp_a1);
    chk({p, "_we_sel"}, {f_we, f_sel}, v.fetch ? {1'b0, 8'hFF} : {v.wr, v.sel});
    if (!v.fetch && v.wr) chk({p, "_dato"}, f_dato, v.dato);
    chk({p, "_err"}, got_err, v.exp_err);
    chk({p, "_data"}, got_dat, v.exp_dat);
    @(posedge clk);
    #2;
    chk({p, "_ack_err_clear"}, {i_ack, i_err, d_ack, d_err, m_cyc}, 5'b0);
    bus_mute = 1'b0;
    bus_rd_q.delete();
  endtask

  // ---------------- round-robin with both requesters held high ----------------
  task automatic tie_seq();
    int          gap;
    bit          found, prev;
    logic [23:0] expa;
    bus_ws = 0; ws_rand = 1'b0; bus_mute = 1'b0;
    i_adr = 24'h000040;
    d_adr = 24'h000080; d_sel = 8'h0F; d_wr = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
        @(posedge clk);
        #2;
        if (m_cyc && !prev) found = 1'b1;
        else if (!m_cyc) gap++;
        prev = m_cyc;
      end
      expa = (k % 2 == 0) ? 24'h000040 : 24'h000080;
      chk($sformatf("tie_grant%0d_found", k), found, 1'b1);
      chk($sformatf("tie_grant%0d_adr", k), m_adr, expa);
      chk($sformatf("tie_grant%0d_idle_gap", k), gap, (k == 0) ? 0 : 2);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (8) @(posedge clk);
    #2;
  endtask

  // ---------------- reset asserted during fetch beat 1 ----------------
  task automatic rst_mid_fetch();
    bit found, saw_ack, got_ack;
    bus_ws = 2; ws_rand = 1'b0; bus_mute = 1'b0;
    i_adr = 24'h000300;
    i_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk);
      #2;
      if (m_cyc && m_ack) found = 1'b1;
    end
    chk("rstmid_beat0_seen", found, 1'b1);
    @(posedge clk);
    #2;
    chk("rstmid_if1_cyc_adr", {m_cyc, m_adr}, {1'b1, 24'h000308});
    rst = 1'b1;
    #1;
    chk("rstmid_mcyc_async_drop", m_cyc, 1'b0);
    saw_ack = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      saw_ack = saw_ack | i_ack | d_ack;
    end
    chk("rstmid_no_ack", saw_ack, 1'b0);
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk);
      #2;
      if (m_cyc) found = 1'b1;
    end
    chk("rstmid_restart_adr", {found, m_adr}, {1'b1, 24'h000300});
    got_ack = 1'b0;
    for (int c = 0; c < 50 && !got_ack; c++) begin
      @(posedge clk);
      #2;
      if (i_ack) got_ack = 1'b1;
    end
    chk("rstmid_restart_ack", got_ack, 1'b1);
    chk("rstmid_restart_dat", i_dat, {pat(24'h000308), pat(24'h000300)});
    i_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  // ---------------- randomized run vs transaction-level model ----------------
  task automatic rand_phase();
    int          done = 0, cyc = 0, stall = 0;
    int          igap, dgap, expp;
    int          inflight = -1;
    int          last_served = 1;   // data served last after reset
    bit          mcq = 1'b0;
    logic [23:0] il, dl;
    do_reset();
    ws_rand = 1'b1; bus_mute = 1'b0; bus_ws = $urandom_range(0, 3);
    igap = $urandom_range(0, 3);
    dgap = $urandom_range(0, 3);
    while (done < 200 && cyc < 8000 && stall < 300) begin
      @(posedge clk);
      #2;
      cyc++;
      stall++;
      if (m_cyc && !mcq) begin
        chk("rnd_grant_has_req", i_req | d_req, 1'b1);
        if (i_req && d_req) expp = (last_served == 1) ? 0 : 1;
        else expp = i_req ? 0 : 1;
        chk("rnd_grant_adr", m_adr,
            (expp == 0) ? {i_adr[23:4], 4'h0} : {d_adr[23:3], 3'b000});
        chk("rnd_grant_ctl", {m_we, m_sel}, (expp == 0) ? {1'b0, 8'hFF} : {d_wr, d_sel});
        if (expp == 1 && d_wr) chk("rnd_store_data", m_dato, d_dato);
        inflight = expp;
        last_served = expp;
      end
      mcq = m_cyc;
      if (i_ack || d_ack) begin
        chk("rnd_ack_port", {i_ack, d_ack}, (inflight == 0) ? 2'b10 : 2'b01);
        if (i_ack) begin
          il = {i_adr[23:4], 4'h0};
          chk("rnd_i_err", i_err, 1'b0);
          chk("rnd_i_dat", i_dat, {pat(il + 24'd8), pat(il)});
          i_req = 1'b0;
          igap = $urandom_range(0, 5);
        end
        if (d_ack) begin
          dl = {d_adr[23:3], 3'b000};
          chk("rnd_d_err", d_err, 1'b0);
          if (!d_wr) chk("rnd_d_dati", d_dati, pat(dl));
          d_req = 1'b0;
          dgap = $urandom_range(0, 5);
        end
        inflight = -1;
        done++;
        stall = 0;
      end
      if (!i_req) begin
        if (igap == 0) begin
          i_adr = 24'($urandom);
          i_req = 1'b1;
        end else igap--;
      end
      if (!d_req) begin
        if (dgap == 0) begin
          d_wr   = 1'($urandom_range(0, 1));
          d_sel  = 8'($urandom);
          d_adr  = 24'($urandom);
          d_dato = {$urandom, $urandom};
          d_req  = 1'b1;
        end else dgap--;
      end
    end
    chk("rnd_progress", done >= 200, 1'b1);
    i_req = 1'b0;
    d_req = 1'b0;
    ws_rand = 1'b0;
    repeat (10) @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'hFF, 24'h000105, 64'h0, 0, 64'hA5, 64'h0,
                24'h000100, 24'h0, 2, 1'b0, 128'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'h0F, 24'h000208, 64'h1122334455667788, 1, 64'h0, 64'h0,
                24'h000208, 24'h0, 3, 1'b0, 128'hA5};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 24'h00123C, 64'h0, 2,
                64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                24'h001230, 24'h001238, 7, 1'b0,
                {64'hFEDCBA9876543210, 64'h0123456789ABCDEF}};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 24'h000400, 64'h0, -1, 64'h0, 64'h0,
                24'h000400, 24'h0, 65, 1'b1, 128'h0};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 24'hFFFFF4, 64'h0, 0, 64'h55, 64'h66,
                24'hFFFFF0, 24'hFFFFF8, 3, 1'b0, {64'h66, 64'h55}};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 24'h000500, 64'h0, -1, 64'h0, 64'h0,
                24'h000500, 24'h0, 65, 1'b1, 128'h0};
    vecs[6] = '{1'b0, 1'b0, 8'hF0, 24'h00ABCF, 64'h0, 3, 64'hDEADBEEFCAFEF00D, 64'h0,
                24'h00ABC8, 24'h0, 5, 1'b0, 128'hDEADBEEFCAFEF00D};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_m_ctl", {m_cyc, m_we, m_sel}, 10'h0);
    chk("reset_m_adr", m_adr, 24'h0);
    chk("reset_m_dato", m_dato, 64'h0);
    chk("reset_i_ack_err", {i_ack, i_err}, 2'b0);
    chk("reset_i_dat", i_dat, 128'h0);
    chk("reset_d_ack_err", {d_ack, d_err}, 2'b0);
    chk("reset_d_dati", d_dati, 64'h0);
    rst = 1'b0;

    tie_seq();
    rst_mid_fetch();
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);
    rand_phase();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
